divider: RTL

- Sequential signed divider: 8-bit signed dividend by 4-bit signed divisor, giving 8-bit signed quotient and 4-bit signed remainder.
- Inverse operation of the ALU's multiply path: operand widths mirror it (mul: 4×4→8; div: 8÷4→8 rem 4).
- Sits beside the ALU in the datapath and is driven by the controller through a start/done handshake.
- Uses a restoring shift-subtract algorithm, one quotient bit per cycle.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/div_step.sv | 37 +++
 rtl/divider.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU-side datapath blocks.
//   - default operand widths for the sequential divider
//     (it mirrors the 4x4->8 multiply path)
//   - divider FSM state encoding
//   - the quotient pattern reported on signed overflow
package alu_pkg;

    localparam int DW_DEF = 8;  // dividend / quotient width, also the iteration count
    localparam int SW_DEF = 4;  // divisor / remainder width

    // -128 / -1 cannot be represented; the divider reports this pattern with ovf=1.
    localparam logic [7:0] OVF_QUOT = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration on magnitudes.
// Ports:
//   rem_in   [SW:0]   partial remainder before the step
//   quo_in   [DW-1:0] quotient register before the step (holds the unconsumed
//                     dividend bits in its upper part)
//   dvs      [SW-1:0] |divisor|, unsigned
//   rem_out  [SW:0]   partial remainder after the step
//   quo_out  [DW-1:0] quotient register after the step
module div_step #(
    parameter int DW = 8,
    parameter int SW = 4
) (
    input  logic [SW:0]   rem_in,
    input  logic [DW-1:0] quo_in,
    input  logic [SW-1:0] dvs,
    output logic [SW:0]   rem_out,
    output logic [DW-1:0] quo_out
);

    // One spare bit above the remainder so the shifted value can never wrap
    // before the compare.
    logic [SW+1:0] shifted;
    logic          ge;

    always_comb begin
        shifted = {rem_in, quo_in[DW-1]};
        ge      = (shifted >= {2'b00, dvs});
        if (ge) begin
            rem_out = (SW+1)'(shifted - {2'b00, dvs});
            quo_out = {quo_in[DW-2:0], 1'b1};
        end else begin
            rem_out = shifted[SW:0];
            quo_out = {quo_in[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// divider: sequential signed divider, DW-bit dividend by SW-bit divisor,
// restoring algorithm, one quotient bit per clock. Results truncate toward
// zero (same as Verilog / and %).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   dividend   signed dividend, sampled on the accepting edge
//   divisor    signed divisor, sampled on the accepting edge
//   quotient   signed quotient, held until the next completion
//   remainder  signed remainder, held until the next completion
//   busy       high from the accepting edge until back in idle
//   done       one-cycle pulse while results are fresh
//   dbz        divide-by-zero flag of the last operation
//   ovf        overflow flag of the last operation (-128 / -1)
module divider
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] dividend,
    input  logic signed [SW-1:0] divisor,
    output logic signed [DW-1:0] quotient,
    output logic signed [SW-1:0] remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 dbz,
    output logic                 ovf
);

    localparam int CW = $clog2(DW);

    div_state_t    state, state_nxt;

    logic [SW:0]   rem_r;      // partial remainder magnitude
    logic [DW-1:0] quo_r;      // dividend magnitude shifting out, quotient shifting in
    logic [SW-1:0] dvs_mag;    // |divisor|; |-2^(SW-1)| still fits unsigned
    logic          neg_q;      // operand signs differ
    logic          neg_r;      // dividend negative
    logic          ovf_pend;   // operands were the single overflowing pair
    logic [CW-1:0] cnt;

    logic [SW:0]   rem_nxt;
    logic [DW-1:0] quo_nxt;

    logic          accept;
    logic          div_zero;
    logic          is_ovf;

    function automatic logic [DW-1:0] neg_if_dw(input logic [DW-1:0] v, input logic n);
        return n ? ((~v) + DW'(1)) : v;
    endfunction

    function automatic logic [SW-1:0] neg_if_sw(input logic [SW-1:0] v, input logic n);
        return n ? ((~v) + SW'(1)) : v;
    endfunction

    div_step #(
        .DW (DW),
        .SW (SW)
    ) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .dvs     (dvs_mag),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign accept   = (state == ST_IDLE) && start;
    assign div_zero = (divisor == '0);
    assign is_ovf   = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = div_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == CW'(DW - 1)) begin
                    state_nxt = ST_SIGN;
                end
            end
            ST_SIGN: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, working registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf_pend  <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                neg_q    <= dividend[DW-1] ^ divisor[SW-1];
                neg_r    <= dividend[DW-1];
                quo_r    <= neg_if_dw(dividend, dividend[DW-1]);
                dvs_mag  <= neg_if_sw(divisor, divisor[SW-1]);
                ovf_pend <= is_ovf;
                rem_r    <= '0;
                cnt      <= '0;
                // A zero divisor skips the iterations and reports right away.
                if (div_zero) begin
                    quotient  <= '0;
                    remainder <= '0;
                    dbz       <= 1'b1;
                    ovf       <= 1'b0;
                end
            end

            if (state == ST_CALC) begin
                rem_r <= rem_nxt;
                quo_r <= quo_nxt;
                cnt   <= cnt + CW'(1);
            end

            // Sign fix-up: the final remainder magnitude is below |divisor|,
            // so its low SW bits carry it completely.
            if (state == ST_SIGN) begin
                quotient  <= ovf_pend ? DW'(OVF_QUOT) : neg_if_dw(quo_r, neg_q);
                remainder <= neg_if_sw(rem_r[SW-1:0], neg_r);
                dbz       <= 1'b0;
                ovf       <= ovf_pend;
            end
        end
    end

endmodule
